ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8: RAM word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16: RAM word width.
REQ-003 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have ports reqN_valid, input, 1 (N=0,1): requester N presents a command.
REQ-006 SHALL have ports reqN_ready, output, 1: arbiter accepts requester N's command this cycle.
REQ-007 SHALL have ports reqN_we, input, 1: 1 = write, 0 = read.
REQ-008 SHALL have ports reqN_addr, input, ADDR_WIDTH: word address.
REQ-009 SHALL have ports reqN_wdata, input, DATA_WIDTH: write data.
REQ-010 SHALL have ports rspN_valid, output, 1: read data for requester N is valid.
REQ-011 SHALL have ports rspN_ready, input, 1: requester N consumes the response.
REQ-012 SHALL have ports rspN_rdata, output, DATA_WIDTH: read data.
REQ-013 SHALL have ports ram_we / ram_re, output, 1: RAM write / read enables.
REQ-014 SHALL have ports ram_waddr / ram_raddr, output, ADDR_WIDTH: RAM addresses.
REQ-015 SHALL have port ram_wdata, output, DATA_WIDTH; ram_rdata, input, DATA_WIDTH (1-cycle registered read, held while ram_re low).
REQ-016 SHALL have port busy, output, 1: FSM not in IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, CMD, RSP.
REQ-018 IDLE: reqN_ready SHALL be high only for the granted requester, combinationally from reqN_valid; handshake (valid & ready) latches we/addr/wdata/grant id into registers and moves to CMD.
REQ-019 CMD: ram_we=latched we, ram_re=~latched we, for exactly one cycle; write -> IDLE; read -> RSP.
REQ-020 RSP: rspG_valid=1 and rspG_rdata=ram_rdata for granted G; the other rsp_valid SHALL stay 0; leave to IDLE on rspG_ready.
REQ-021 Latency: write accepted cycle N -> ram_we high cycle N+1; read accepted cycle N -> rsp_valid high cycle N+2.
REQ-022 reqN_ready SHALL be 0 in CMD and RSP; at most one reqN_ready high per cycle.
REQ-023 ram_waddr and ram_raddr SHALL both carry the latched address; ram_wdata the latched data.
REQ-024 Both requesters valid in IDLE: winner per REQ-030/031; loser waits with valid held, no data lost.
REQ-025 rspN_rdata SHALL be don't-care-stable (0) when rspN_valid low.
REQ-026 rspG_ready asserted in the first RSP cycle SHALL complete the response in that cycle; back-to-back next command accepted the following cycle.

Reset
REQ-027 rst_n low SHALL asynchronously force state IDLE, all ready/valid/ram enables 0, latched regs 0, busy 0.
REQ-028 Reset mid-CMD or mid-RSP SHALL abort the operation; no RAM enable pulses after rst_n falls.
REQ-029 Round-robin pointer SHALL reset to favour requester 0.

Configuration
REQ-030 With RAM_ARB_ROUND_ROBIN_EN defined: on contention grant the requester not granted last; pointer updates only on a handshake.
REQ-031 Without it: fixed priority, requester 0 always wins contention.

Structure
REQ-032 State encoding and requester-id type SHALL live in shared package ram_arb_pkg.
REQ-033 Grant logic SHALL be sub-module ram_arb_grant (valids, last-grant in; one-hot grant out).

Verification
REQ-034 Write: req0 we=1 addr=0x12 wdata=0xBEEF -> ram_we=1, ram_waddr=0x12, ram_wdata=0xBEEF next cycle; busy 1 cycle.
REQ-035 Read: RAM[0x12]=0xBEEF, req1 read 0x12 -> rsp1_valid=1, rsp1_rdata=0xBEEF two cycles after accept; rsp0_valid stays 0.
REQ-036 Contention: both valid continuously, alternating addrs -> with macro grants alternate 0,1,0,1; without, req0 served until it drops valid.
REQ-037 Backpressure: rsp0_ready low 5 cycles -> rsp0_valid and data held, req1_ready stays 0 throughout.
REQ-038 Reset in RSP: rst_n low -> busy, rsp_valid, ram_we, ram_re all 0 immediately; first request after release served in 1 (write) / 2 (read) cycles.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg
//   Shared types and constants for the two-requester RAM arbiter.
//   Contents:
//     arb_state_e   - arbiter FSM encoding (IDLE / CMD / RSP)
//     req_id_t      - requester identifier (0 or 1)
//     NUM_REQ       - number of requesters
//     RESET_LAST_ID - value loaded into the last-grant pointer on reset
package ram_arb_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_RSP  = 2'd2
  } arb_state_e;

  typedef logic req_id_t;

  // The pointer records the requester granted last. Starting at 1 means the
  // first contended grant goes to requester 0.
  localparam req_id_t RESET_LAST_ID = 1'b1;

endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if
//   Bundle of the requester command/response channels and the RAM port.
//   Parameters: ADDR_WIDTH (word address width), DATA_WIDTH (word width).
//   Signals:
//     reqN_valid/ready/we/addr/wdata  - command channel of requester N
//     rspN_valid/ready/rdata          - read response channel of requester N
//     ram_we/ram_re/ram_waddr/ram_raddr/ram_wdata/ram_rdata - RAM port
//   Modports:
//     slave  - the arbiter side
//     master - the requesters plus RAM side (test environment)
//
//   Handshake rule for every valid/ready pair: a transfer happens on a
//   rising clock edge where both valid and ready are high; the sender holds
//   valid and its payload stable until that edge, and never withdraws valid
//   before the transfer.
interface ram_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
);

  logic                  req0_valid;
  logic                  req0_ready;
  logic                  req0_we;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0] req0_wdata;

  logic                  req1_valid;
  logic                  req1_ready;
  logic                  req1_we;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0] req1_wdata;

  logic                  rsp0_valid;
  logic                  rsp0_ready;
  logic [DATA_WIDTH-1:0] rsp0_rdata;

  logic                  rsp1_valid;
  logic                  rsp1_ready;
  logic [DATA_WIDTH-1:0] rsp1_rdata;

  logic                  ram_we;
  logic                  ram_re;
  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic [ADDR_WIDTH-1:0] ram_raddr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
    input  rsp0_ready, rsp1_ready,
    output ram_we, ram_re, ram_waddr, ram_raddr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
    output rsp0_ready, rsp1_ready,
    input  ram_we, ram_re, ram_waddr, ram_raddr, ram_wdata,
    output ram_rdata
  );

endinterface

// File: rtl/ram_arb_grant.sv
// ram_arb_grant
//   Combinational grant selection between the two requesters.
//   Ports:
//     valid_i [1:0] - command valid of each requester
//     last_i        - requester granted on the most recent handshake
//     gnt_o   [1:0] - one-hot grant (all zero when nobody is valid)
//   Build option:
//     RAM_ARB_ROUND_ROBIN_EN defined   - on contention grant the requester
//                                        that was not granted last
//     RAM_ARB_ROUND_ROBIN_EN undefined - fixed priority, requester 0 wins
module ram_arb_grant
  import ram_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] valid_i,
  input  req_id_t            last_i,
  output logic [NUM_REQ-1:0] gnt_o
);

`ifdef RAM_ARB_ROUND_ROBIN_EN
  always_comb begin
    gnt_o = '0;
    if (valid_i == 2'b11) begin
      gnt_o = (last_i == 1'b1) ? 2'b01 : 2'b10;
    end else if (valid_i[0]) begin
      gnt_o = 2'b01;
    end else if (valid_i[1]) begin
      gnt_o = 2'b10;
    end
  end
`else
  always_comb begin
    gnt_o = '0;
    if (valid_i[0]) begin
      gnt_o = 2'b01;
    end else if (valid_i[1]) begin
      gnt_o = 2'b10;
    end
  end

  // The pointer has no effect under fixed priority.
  logic unused_last;
  assign unused_last = last_i;
`endif

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Serialises read/write commands from two requesters onto a single RAM
//   port with a 1-cycle registered read.
//   Parameters: ADDR_WIDTH (default 8), DATA_WIDTH (default 16).
//   Ports:
//     clk     - clock, rising edge
//     rst_n   - asynchronous active-low reset
//     bus     - ram_arbiter_if.slave: requester channels and RAM port
//     busy    - FSM is not in IDLE
//     state_o - current FSM state (debug)
//   Operation: IDLE accepts one command from the granted requester, CMD
//   drives the RAM enable for one cycle, RSP (reads only) presents the RAM
//   read data until the owning requester takes it.
//   Build option RAM_ARB_ROUND_ROBIN_EN selects round-robin arbitration in
//   ram_arb_grant; otherwise requester 0 has fixed priority.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  ram_arbiter_if.slave  bus,
  output logic          busy,
  output arb_state_e    state_o
);

  arb_state_e            state_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  req_id_t               gnt_id_q;
  req_id_t               last_q;
  logic                  ram_we_q;
  logic                  ram_re_q;
  logic                  rsp_valid_q;

  logic [NUM_REQ-1:0]    valid_vec;
  logic [NUM_REQ-1:0]    gnt;
  logic                  idle;
  logic                  hs0;
  logic                  hs1;
  logic                  hs;
  req_id_t               sel_id;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  rsp_ready_g;

  assign valid_vec = {bus.req1_valid, bus.req0_valid};

  ram_arb_grant u_grant (
    .valid_i (valid_vec),
    .last_i  (last_q),
    .gnt_o   (gnt)
  );

  assign idle = (state_q == ST_IDLE);

  // Ready is only offered in IDLE and to the one granted requester; gating
  // with rst_n keeps it low while reset is held.
  assign bus.req0_ready = rst_n & idle & gnt[0];
  assign bus.req1_ready = rst_n & idle & gnt[1];

  assign hs0 = bus.req0_valid & bus.req0_ready;
  assign hs1 = bus.req1_valid & bus.req1_ready;
  assign hs  = hs0 | hs1;

  // Grants are one-hot, so a requester-1 handshake alone identifies the source.
  assign sel_id    = hs1;
  assign sel_we    = hs1 ? bus.req1_we    : bus.req0_we;
  assign sel_addr  = hs1 ? bus.req1_addr  : bus.req0_addr;
  assign sel_wdata = hs1 ? bus.req1_wdata : bus.req0_wdata;

  assign rsp_ready_g = gnt_id_q ? bus.rsp1_ready : bus.rsp0_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      gnt_id_q    <= 1'b0;
      last_q      <= RESET_LAST_ID;
      ram_we_q    <= 1'b0;
      ram_re_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ram_we_q <= 1'b0;
          ram_re_q <= 1'b0;
          if (hs) begin
            we_q     <= sel_we;
            addr_q   <= sel_addr;
            wdata_q  <= sel_wdata;
            gnt_id_q <= sel_id;
            last_q   <= sel_id;
            // RAM enables are registered so they are high for exactly the CMD cycle.
            ram_we_q <= sel_we;
            ram_re_q <= ~sel_we;
            state_q  <= ST_CMD;
          end
        end
        ST_CMD: begin
          ram_we_q <= 1'b0;
          ram_re_q <= 1'b0;
          if (we_q) begin
            state_q <= ST_IDLE;
          end else begin
            // RAM data appears on the edge that enters RSP.
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RSP;
          end
        end
        ST_RSP: begin
          ram_we_q <= 1'b0;
          ram_re_q <= 1'b0;
          if (rsp_ready_g) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          ram_we_q    <= 1'b0;
          ram_re_q    <= 1'b0;
          rsp_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.rsp0_valid = rsp_valid_q & ~gnt_id_q;
  assign bus.rsp1_valid = rsp_valid_q &  gnt_id_q;
  // Read data is forced to 0 whenever its channel is not valid.
  assign bus.rsp0_rdata = bus.rsp0_valid ? bus.ram_rdata : '0;
  assign bus.rsp1_rdata = bus.rsp1_valid ? bus.ram_rdata : '0;

  assign bus.ram_we    = ram_we_q;
  assign bus.ram_re    = ram_re_q;
  assign bus.ram_waddr = addr_q;
  assign bus.ram_raddr = addr_q;
  assign bus.ram_wdata = wdata_q;

  assign busy    = ~idle;
  assign state_o = state_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
//   Self-checking bench for ram_arbiter: a behavioural RAM with a 1-cycle
//   registered read, directed scenarios (write, read, contention,
//   backpressure, reset during a response) and a short random phase.
//   Expected RAM writes and read data come from a shadow memory and are
//   queued at command acceptance, then popped when the DUT produces them.
module tb_ram_arbiter;
  import ram_arb_pkg::*;

  localparam int AW = 8;
  localparam int DW = 16;

  logic       clk;
  logic       rst_n;
  logic       busy;
  arb_state_e dbg_state;

  ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .busy    (busy),
    .state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- RAM model ----------------
  logic [DW-1:0] mem    [256];
  logic [DW-1:0] shadow [256];

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]    = '0;
      shadow[i] = '0;
    end
    bus.ram_rdata = '0;
  end

  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_waddr] <= bus.ram_wdata;
    if (bus.ram_re) bus.ram_rdata <= mem[bus.ram_raddr];
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [AW+DW-1:0] wr_q   [$];
  logic [DW-1:0]    rsp0_q [$];
  logic [DW-1:0]    rsp1_q [$];
  logic [1:0]       gnt_q  [$];
  int               acc_cyc  = 0;
  bit               rsp_seen = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_ram_we", bus.ram_we, 1'b0);
      check("rst_ram_re", bus.ram_re, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_rsp_valid", {bus.rsp1_valid, bus.rsp0_valid}, 2'b00);
      check("rst_ready", {bus.req1_ready, bus.req0_ready}, 2'b00);
      check("rst_state", dbg_state, ST_IDLE);
      wr_q.delete();
      rsp0_q.delete();
      rsp1_q.delete();
      rsp_seen = 0;
    end else begin
      check("one_ready", bus.req0_ready & bus.req1_ready, 1'b0);
      if (busy) check("ready_busy", bus.req0_ready | bus.req1_ready, 1'b0);
      check("rsp_both", bus.rsp0_valid & bus.rsp1_valid, 1'b0);
      if (!bus.rsp0_valid) check("rsp0_idle_data", bus.rsp0_rdata, 0);
      if (!bus.rsp1_valid) check("rsp1_idle_data", bus.rsp1_rdata, 0);

      if (bus.ram_we) begin
        check("we_lat", cyc, acc_cyc + 1);
        check("addr_match", bus.ram_raddr, bus.ram_waddr);
        if (wr_q.size() == 0) check("wr_unexpected", 1, 0);
        else check("wr_addr_data", {bus.ram_waddr, bus.ram_wdata}, wr_q.pop_front());
      end
      if (bus.ram_re) check("re_lat", cyc, acc_cyc + 1);

      if ((bus.rsp0_valid | bus.rsp1_valid) && !rsp_seen) begin
        check("rsp_lat", cyc, acc_cyc + 2);
        rsp_seen = 1;
      end
      if (bus.rsp0_valid && bus.rsp0_ready) begin
        if (rsp0_q.size() == 0) check("rsp0_unexpected", 1, 0);
        else check("rsp0_data", bus.rsp0_rdata, rsp0_q.pop_front());
        rsp_seen = 0;
      end
      if (bus.rsp1_valid && bus.rsp1_ready) begin
        if (rsp1_q.size() == 0) check("rsp1_unexpected", 1, 0);
        else check("rsp1_data", bus.rsp1_rdata, rsp1_q.pop_front());
        rsp_seen = 0;
      end

      if (bus.req0_valid && bus.req0_ready) begin
        acc_cyc = cyc;
        gnt_q.push_back(2'd0);
        if (bus.req0_we) begin
          wr_q.push_back({bus.req0_addr, bus.req0_wdata});
          shadow[bus.req0_addr] = bus.req0_wdata;
        end else begin
          rsp0_q.push_back(shadow[bus.req0_addr]);
        end
      end
      if (bus.req1_valid && bus.req1_ready) begin
        acc_cyc = cyc;
        gnt_q.push_back(2'd1);
        if (bus.req1_we) begin
          wr_q.push_back({bus.req1_addr, bus.req1_wdata});
          shadow[bus.req1_addr] = bus.req1_wdata;
        end else begin
          rsp1_q.push_back(shadow[bus.req1_addr]);
        end
      end
    end
  end

  // ---------------- random response backpressure ----------------
  bit rand_rdy = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) begin
        bus.rsp0_ready = 1'($urandom_range(0, 1));
        bus.rsp1_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int n, input logic v, input logic we,
                         input logic [AW-1:0] addr, input logic [DW-1:0] data);
    if (n == 0) begin
      bus.req0_valid = v; bus.req0_we = we; bus.req0_addr = addr; bus.req0_wdata = data;
    end else begin
      bus.req1_valid = v; bus.req1_we = we; bus.req1_addr = addr; bus.req1_wdata = data;
    end
  endtask

  function automatic bit hs_of(input int n);
    return (n == 0) ? (bus.req0_valid && bus.req0_ready) : (bus.req1_valid && bus.req1_ready);
  endfunction

  // Presents one command, waits (bounded) for acceptance, then drops valid.
  task automatic do_req(input int n, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data);
    bit done;
    done = 0;
    set_req(n, 1'b1, we, addr, data);
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (hs_of(n)) done = 1;
    end
    if (!done) check("req_timeout", 0, 1);
    @(posedge clk);
    #1;
    set_req(n, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 80 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1;
    end
    if (!done) check("idle_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    bit ok;
    int rcyc;
    logic [1:0] exp_gnt [4];

    rst_n = 1'b0;
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    #1;
    check("reset_busy", busy, 1'b0);
    check("reset_ram_we", bus.ram_we, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Write: busy for exactly one cycle
    do_req(0, 1'b1, 8'h12, 16'hBEEF);
    @(negedge clk);
    check("wr_busy_cmd", busy, 1'b1);
    @(negedge clk);
    check("wr_busy_done", busy, 1'b0);

    // Read by requester 1 of the same word
    do_req(1, 1'b0, 8'h12, 16'h0000);
    wait_idle();

    // Backpressure on requester 0 with requester 1 waiting
    bus.rsp0_ready = 1'b0;
    set_req(0, 1'b1, 1'b0, 8'h12, 16'h0000);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (hs_of(0)) ok = 1;
    end
    if (!ok) check("bp_accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b1, 1'b1, 8'h30, 16'h1234);
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (bus.rsp0_valid) ok = 1;
    end
    if (!ok) check("bp_rsp_timeout", 0, 1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("bp_valid_held", bus.rsp0_valid, 1'b1);
      check("bp_data_held", bus.rsp0_rdata, 16'hBEEF);
      check("bp_req1_blocked", bus.req1_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    bus.rsp0_ready = 1'b1;
    @(negedge clk);
    check("bp_release", bus.rsp0_valid & bus.rsp0_ready, 1'b1);
    rcyc = cyc;
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (hs_of(1)) ok = 1;
    end
    check("b2b_accept", cyc, rcyc + 1);
    @(posedge clk);
    #1;
    set_req(1, 1'b0, 1'b0, '0, '0);
    wait_idle();

    // Reset while a read response is pending
    bus.rsp0_ready = 1'b0;
    do_req(0, 1'b0, 8'h30, 16'h0000);
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (bus.rsp0_valid) ok = 1;
    end
    if (!ok) check("rst_rsp_timeout", 0, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_rsp0_valid", bus.rsp0_valid, 1'b0);
    check("rstmid_ram_we", bus.ram_we, 1'b0);
    check("rstmid_ram_re", bus.ram_re, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.rsp0_ready = 1'b1;
    do_req(0, 1'b1, 8'h55, 16'hA5A5);
    do_req(0, 1'b0, 8'h55, 16'h0000);
    wait_idle();

    // Contention from a fresh reset: both valid, addresses step per grant
    apply_reset();
    gnt_q.delete();
    set_req(0, 1'b1, 1'b1, 8'h20, 16'h0100);
    set_req(1, 1'b1, 1'b1, 8'h40, 16'h0200);
    for (int i = 0; i < 40 && gnt_q.size() < 4; i++) begin
      bit h0, h1;
      @(negedge clk);
      h0 = hs_of(0);
      h1 = hs_of(1);
      @(posedge clk);
      #1;
      if (h0) begin bus.req0_addr = bus.req0_addr + 8'd1; bus.req0_wdata = bus.req0_wdata + 16'd1; end
      if (h1) begin bus.req1_addr = bus.req1_addr + 8'd1; bus.req1_wdata = bus.req1_wdata + 16'd1; end
    end
    bus.req0_valid = 1'b0;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (hs_of(1)) ok = 1;
    end
    if (!ok) check("cont_req1_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.req1_valid = 1'b0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    exp_gnt = '{2'd0, 2'd1, 2'd0, 2'd1};
`else
    exp_gnt = '{2'd0, 2'd0, 2'd0, 2'd0};
`endif
    check("cont_count", gnt_q.size(), 5);
    for (int i = 0; i < 4; i++) begin
      if (gnt_q.size() > 0) check("cont_order", gnt_q.pop_front(), exp_gnt[i]);
    end
    if (gnt_q.size() > 0) check("cont_after_drop", gnt_q.pop_front(), 2'd1);
    wait_idle();

    // Random sequential traffic with random response backpressure
    rand_rdy = 1;
    for (int t = 0; t < 24; t++) begin
      do_req(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             8'($urandom_range(0, 15)), 16'($urandom_range(0, 65535)));
    end
    wait_idle();
    rand_rdy = 0;
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    repeat (3) @(negedge clk);

    check("end_wr_q_empty", wr_q.size(), 0);
    check("end_rsp0_q_empty", rsp0_q.size(), 0);
    check("end_rsp1_q_empty", rsp1_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
